tag_pool_logic: RTL
===================

Name: tag_pool_logic

Overview:
- Multi-tag buffer manager; generalises single-tag double-buffer control to NUM_TAGS buffers.
- Each tag runs its own FSM: FREE -> LDMEM -> COMPUTE -> COMPUTE_CHECK -> STMEM -> FREE.
- Sits between the instruction/controller front end and the ldmem, compute and stmem engines.
- Allocates tags round-robin. Each engine stage serves tags strictly in allocation order through its own pointer.

Parameters:
- NUM_TAGS, 2, number of buffer tags (>=2).
- TAG_W, 1, tag index width; must equal clog2(NUM_TAGS).
- REUSE_CNT_W, 3, width of the per-tag reuse counter.
- STORE_ENABLED, 1, 1: COMPUTE_CHECK exits to STMEM; 0: exits straight to FREE and the stmem stage is idle.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- tag_req  in  1  allocate the next tag; accepted only when tag_ready=1
- tag_reuse  in  1  one extra compute pass for the last-allocated tag
- tag_flush  in  1  mark the last-allocated tag as final (store/free after its last compute)
- tag_bias_prev_sw  in  1  sideband; captured per tag on req/reuse
- tag_ready  out  1  tag at alloc pointer is FREE
- alloc_tag  out  TAG_W  index the next accepted tag_req receives
- ldmem_tag_ready  out  1  tag at ld pointer is in LDMEM
- ldmem_tag  out  TAG_W  ld pointer
- ldmem_tag_done  in  1  advance the ld tag to COMPUTE
- compute_tag_ready  out  1  tag at compute pointer is in COMPUTE
- compute_tag  out  TAG_W  compute pointer
- compute_bias_prev_sw  out  1  bias sideband of the compute tag for the current pass
- compute_tag_done  in  1  one compute pass finished
- next_compute_tag  out  1  compute tag retiring this cycle
- stmem_tag_ready  out  1  tag at st pointer is in STMEM
- stmem_tag  out  TAG_W  st pointer
- stmem_tag_done  in  1  free the st tag
- tags_free  out  NUM_TAGS  per-tag FREE bitmap

Behaviour:
Reset values:
- All tags FREE; all pointers 0; all counters 0; all flush bits 0.
- tag_ready=1; tags_free all 1; every other output 0.
- Reset mid-operation discards all state the next cycle.

Allocation:
- tag_req && tag_ready: alloc tag goes to LDMEM next cycle with count=1. bias_q and reuse_bias_q both take tag_bias_prev_sw. Alloc pointer increments, wrapping NUM_TAGS-1 -> 0.
- tag_req while tag_ready=0 is ignored; no state change.

Reuse:
- tag_reuse increments the count of the last-allocated tag (alloc pointer - 1 mod NUM_TAGS) and captures reuse_bias_q.
- If tag_req is accepted in the same cycle, tag_reuse applies to the newly allocated tag instead (count=2).
- The count saturates at 2^REUSE_CNT_W-1; a further reuse is dropped.
- Reuse on a FREE tag is ignored.

Flush:
- tag_flush sets the flush bit of the same target tag selection as reuse.
- Ignored if that tag is FREE and no req is accepted this cycle.

ldmem stage:
- ldmem_tag_done && ldmem_tag_ready: LDMEM -> COMPUTE; ld pointer increments.
- A done pulse while not ready is ignored.

Compute stage:
- compute_tag_done && compute_tag_ready: COMPUTE -> COMPUTE_CHECK. Count decrements, unless a reuse hits the same tag in the same cycle (net unchanged). bias_q takes reuse_bias_q.
- COMPUTE_CHECK, count!=0: back to COMPUTE next cycle.
- COMPUTE_CHECK, count==0 and flush=1: next_compute_tag=1 for one cycle. Tag goes to STMEM (or FREE if STORE_ENABLED=0). Flush bit clears; compute pointer increments.
- COMPUTE_CHECK, count==0 and flush=0: tag holds in COMPUTE_CHECK until a flush or reuse arrives.

Store stage:
- stmem_tag_done && stmem_tag_ready: STMEM -> FREE; st pointer increments.

Concurrency and ordering:
- All stages may complete on different tags in the same cycle; each tag's FSM updates independently.
- Latency: every transition takes 1 cycle from the qualifying input edge.
- Ordering invariant: the alloc, ld, compute and st pointers never pass one another.

Optional Feature:
TAG_POOL_ERR_EN
- Defined: adds output tag_err (1 bit, sticky, cleared only by reset).
- tag_err sets on any of:
  - tag_req while not ready;
  - reuse counter saturation;
  - any *_done pulse while the matching *_ready=0;
  - stmem_tag_done when STORE_ENABLED=0.
- Not defined: no port; these events are silently ignored as described above.

Test Plan:
- Reset, then req; ld_done at cycle 3; compute_done at cycle 6 with flush at cycle 1 -> tag0 sequences LDMEM (c2), COMPUTE (c4), CHECK (c7), STMEM (c8). next_compute_tag pulses at c7. stmem_done returns it to FREE and tags_free=2'b11.
- NUM_TAGS=4: four back-to-back reqs -> alloc_tag 0,1,2,3; tag_ready=0 after the 4th. A 5th req is ignored. stmem_done on tag0 -> tag_ready=1 and alloc_tag=0.
- Req, then 2 reuses (count=3) and a flush -> three compute_done pulses are needed. The tag returns to COMPUTE twice, and compute_bias_prev_sw shows reuse_bias_q from pass 2 onward.
- Req with no flush; compute_done -> tag holds in CHECK. A flush 5 cycles later -> STMEM the next cycle.
- STORE_ENABLED=0: flushed tag goes CHECK -> FREE directly. stmem_tag_ready is never 1.
- TAG_POOL_ERR_EN: ldmem_tag_done while ldmem_tag_ready=0 -> tag_err=1 and stays set until reset.

Source files
------------

// File: rtl/tag_pool_logic_if.sv
// Handshake bundle between the front end / engines and the tag pool manager.
// The sticky tag_err flag exists only when TAG_POOL_ERR_EN is defined.
interface tag_pool_logic_if #(
   parameter int unsigned NUM_TAGS = 2,
   parameter int unsigned TAG_W    = 1
);
   logic                tag_req;
   logic                tag_reuse;
   logic                tag_flush;
   logic                tag_bias_prev_sw;
   logic                tag_ready;
   logic [TAG_W-1:0]    alloc_tag;
   logic                ldmem_tag_ready;
   logic [TAG_W-1:0]    ldmem_tag;
   logic                ldmem_tag_done;
   logic                compute_tag_ready;
   logic [TAG_W-1:0]    compute_tag;
   logic                compute_bias_prev_sw;
   logic                compute_tag_done;
   logic                next_compute_tag;
   logic                stmem_tag_ready;
   logic [TAG_W-1:0]    stmem_tag;
   logic                stmem_tag_done;
   logic [NUM_TAGS-1:0] tags_free;
`ifdef TAG_POOL_ERR_EN
   logic                tag_err;
`endif

   modport master (
      output tag_req, tag_reuse, tag_flush, tag_bias_prev_sw,
             ldmem_tag_done, compute_tag_done, stmem_tag_done,
      input  tag_ready, alloc_tag, ldmem_tag_ready, ldmem_tag,
             compute_tag_ready, compute_tag, compute_bias_prev_sw,
             next_compute_tag, stmem_tag_ready, stmem_tag, tags_free
`ifdef TAG_POOL_ERR_EN
      , input tag_err
`endif
   );

   modport slave (
      input  tag_req, tag_reuse, tag_flush, tag_bias_prev_sw,
             ldmem_tag_done, compute_tag_done, stmem_tag_done,
      output tag_ready, alloc_tag, ldmem_tag_ready, ldmem_tag,
             compute_tag_ready, compute_tag, compute_bias_prev_sw,
             next_compute_tag, stmem_tag_ready, stmem_tag, tags_free
`ifdef TAG_POOL_ERR_EN
      , output tag_err
`endif
   );
endinterface

// File: rtl/tag_pool_logic.sv
// Multi-tag buffer manager: per-tag FREE/LDMEM/COMPUTE/CHECK/STMEM FSMs, each stage served in allocation order.
// Define TAG_POOL_ERR_EN to add the sticky protocol-error flag tag_err.
module tag_pool_logic #(
   parameter int unsigned NUM_TAGS      = 2,
   parameter int unsigned TAG_W         = 1,
   parameter int unsigned REUSE_CNT_W   = 3,
   parameter bit          STORE_ENABLED = 1'b1
) (
   input logic             clk,
   input logic             reset,
   tag_pool_logic_if.slave bus
);

   typedef enum logic [2:0] {
      ST_FREE, ST_LDMEM, ST_COMPUTE, ST_CHECK, ST_STMEM
   } tag_state_e;

   localparam logic [REUSE_CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [REUSE_CNT_W-1:0] CNT_ONE  = REUSE_CNT_W'(1);
   localparam logic [TAG_W-1:0]       PTR_LAST = TAG_W'(NUM_TAGS - 1);

   tag_state_e             state_q [NUM_TAGS];
   tag_state_e             state_d [NUM_TAGS];
   logic [REUSE_CNT_W-1:0] cnt_q   [NUM_TAGS];
   logic [REUSE_CNT_W-1:0] cnt_d   [NUM_TAGS];
   logic [NUM_TAGS-1:0]    flush_q, flush_d, bias_q, bias_d, rbias_q, rbias_d;
   logic [TAG_W-1:0]       alloc_ptr_q, alloc_ptr_d, ld_ptr_q, ld_ptr_d;
   logic [TAG_W-1:0]       cmp_ptr_q, cmp_ptr_d, st_ptr_q, st_ptr_d;

   logic                   req_acc_c, ld_acc_c, cmp_acc_c, st_acc_c, retire_c;
   logic [TAG_W-1:0]       last_ptr_c, tgt_ptr_c;
   logic [NUM_TAGS-1:0]    tags_free_c;

   function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + TAG_W'(1);
   endfunction

   // Reuse/flush target the newly allocated tag if a req is accepted, else the last-allocated one.
   assign last_ptr_c = (alloc_ptr_q == '0) ? PTR_LAST : alloc_ptr_q - TAG_W'(1);
   assign req_acc_c  = bus.tag_req && (state_q[alloc_ptr_q] == ST_FREE);
   assign tgt_ptr_c  = req_acc_c ? alloc_ptr_q : last_ptr_c;
   assign ld_acc_c   = bus.ldmem_tag_done && (state_q[ld_ptr_q] == ST_LDMEM);
   assign cmp_acc_c  = bus.compute_tag_done && (state_q[cmp_ptr_q] == ST_COMPUTE);
   assign st_acc_c   = bus.stmem_tag_done && (state_q[st_ptr_q] == ST_STMEM);

   always_comb begin : next_state
      logic                   alloc_hit, tgt_live, reuse_inc, pass_dec, flush_eff;
      logic [REUSE_CNT_W-1:0] base_cnt;
      alloc_hit = 1'b0;
      tgt_live  = 1'b0;
      reuse_inc = 1'b0;
      pass_dec  = 1'b0;
      flush_eff = 1'b0;
      base_cnt  = '0;
      retire_c  = 1'b0;
      flush_d   = flush_q;
      bias_d    = bias_q;
      rbias_d   = rbias_q;
      for (int t = 0; t < int'(NUM_TAGS); t++) begin
         state_d[t] = state_q[t];
         alloc_hit  = req_acc_c && (alloc_ptr_q == TAG_W'(t));
         tgt_live   = (tgt_ptr_c == TAG_W'(t)) && (alloc_hit || (state_q[t] != ST_FREE));
         base_cnt   = alloc_hit ? CNT_ONE : cnt_q[t];
         reuse_inc  = bus.tag_reuse && tgt_live && (base_cnt != CNT_MAX);
         pass_dec   = cmp_acc_c && (cmp_ptr_q == TAG_W'(t));
         flush_eff  = (flush_q[t] && !alloc_hit) || (bus.tag_flush && tgt_live);
         cnt_d[t]   = base_cnt + REUSE_CNT_W'(reuse_inc) - REUSE_CNT_W'(pass_dec);
         flush_d[t] = flush_eff;
         if (alloc_hit) begin
            state_d[t] = ST_LDMEM;
            bias_d[t]  = bus.tag_bias_prev_sw;
            rbias_d[t] = bus.tag_bias_prev_sw;
         end
         if (reuse_inc) rbias_d[t] = bus.tag_bias_prev_sw;
         case (state_q[t])
            ST_LDMEM: begin
               if (ld_acc_c && (ld_ptr_q == TAG_W'(t))) state_d[t] = ST_COMPUTE;
            end
            ST_COMPUTE: begin
               if (pass_dec) begin
                  state_d[t] = ST_CHECK;
                  bias_d[t]  = rbias_q[t];
               end
            end
            // A reuse or flush arriving while parked in CHECK is acted on in the same cycle.
            ST_CHECK: begin
               if (cnt_d[t] != '0) begin
                  state_d[t] = ST_COMPUTE;
               end else if (flush_eff) begin
                  state_d[t] = STORE_ENABLED ? ST_STMEM : ST_FREE;
                  flush_d[t] = 1'b0;
                  retire_c   = 1'b1;
               end
            end
            ST_STMEM: begin
               if (st_acc_c && (st_ptr_q == TAG_W'(t))) state_d[t] = ST_FREE;
            end
            default: ;
         endcase
      end
      alloc_ptr_d = req_acc_c ? ptr_inc(alloc_ptr_q) : alloc_ptr_q;
      ld_ptr_d    = ld_acc_c  ? ptr_inc(ld_ptr_q)    : ld_ptr_q;
      cmp_ptr_d   = retire_c  ? ptr_inc(cmp_ptr_q)   : cmp_ptr_q;
      st_ptr_d    = st_acc_c  ? ptr_inc(st_ptr_q)    : st_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int t = 0; t < int'(NUM_TAGS); t++) begin
            state_q[t] <= ST_FREE;
            cnt_q[t]   <= '0;
         end
         flush_q     <= '0;
         bias_q      <= '0;
         rbias_q     <= '0;
         alloc_ptr_q <= '0;
         ld_ptr_q    <= '0;
         cmp_ptr_q   <= '0;
         st_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flush_q     <= flush_d;
         bias_q      <= bias_d;
         rbias_q     <= rbias_d;
         alloc_ptr_q <= alloc_ptr_d;
         ld_ptr_q    <= ld_ptr_d;
         cmp_ptr_q   <= cmp_ptr_d;
         st_ptr_q    <= st_ptr_d;
      end
   end

   always_comb begin
      tags_free_c = '0;
      for (int t = 0; t < int'(NUM_TAGS); t++) tags_free_c[t] = (state_q[t] == ST_FREE);
   end

   assign bus.tag_ready            = (state_q[alloc_ptr_q] == ST_FREE);
   assign bus.alloc_tag            = alloc_ptr_q;
   assign bus.ldmem_tag_ready      = (state_q[ld_ptr_q] == ST_LDMEM);
   assign bus.ldmem_tag            = ld_ptr_q;
   assign bus.compute_tag_ready    = (state_q[cmp_ptr_q] == ST_COMPUTE);
   assign bus.compute_tag          = cmp_ptr_q;
   assign bus.compute_bias_prev_sw = bias_q[cmp_ptr_q];
   assign bus.next_compute_tag     = retire_c;
   assign bus.stmem_tag_ready      = (state_q[st_ptr_q] == ST_STMEM);
   assign bus.stmem_tag            = st_ptr_q;
   assign bus.tags_free            = tags_free_c;

`ifdef TAG_POOL_ERR_EN
   logic                   sat_c, err_ev_c, tag_err_q;
   logic [REUSE_CNT_W-1:0] tgt_cnt_c;

   assign tgt_cnt_c = req_acc_c ? CNT_ONE : cnt_q[tgt_ptr_c];
   assign sat_c     = bus.tag_reuse && (req_acc_c || (state_q[tgt_ptr_c] != ST_FREE))
                      && (tgt_cnt_c == CNT_MAX);
   assign err_ev_c  = (bus.tag_req && !req_acc_c) || sat_c
                      || (bus.ldmem_tag_done && !ld_acc_c)
                      || (bus.compute_tag_done && !cmp_acc_c)
                      || (bus.stmem_tag_done && !st_acc_c)
                      || (bus.stmem_tag_done && !STORE_ENABLED);

   always_ff @(posedge clk) begin
      if (reset)         tag_err_q <= 1'b0;
      else if (err_ev_c) tag_err_q <= 1'b1;
   end

   assign bus.tag_err = tag_err_q;
`endif

endmodule
